// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C phase-1 master: FSM encoding, default address, frame size.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    LOAD       = 3'd2,
    SEND       = 3'd3,
    ACK        = 3'd4,
    STOP_SETUP = 3'd5,
    STOP_WAIT  = 3'd6,
    STOP       = 3'd7
  } state_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h48;
  localparam logic [3:0] BIT_COUNT          = 4'd8;

endpackage

// File: rtl/i2c_scl_gen.sv
// SCL divider: toggles SCL every SCL_HALF clocks while enabled, idles high when disabled.
// The one-shot pulses are registered together with SCL, so they mark the transition cycle.
module i2c_scl_gen #(
  parameter int unsigned SCL_HALF = 4
) (
  input  logic clock,
  input  logic Reset,
  input  logic en,
  output logic SCL,
  output logic OneShotNegative,
  output logic OneShotPositive
);

  localparam int unsigned CW = (SCL_HALF > 1) ? $clog2(SCL_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          scl_q, scl_d;
  logic          neg_q, neg_d;
  logic          pos_q, pos_d;

  always_comb begin
    cnt_d = cnt_q;
    scl_d = scl_q;
    neg_d = 1'b0;
    pos_d = 1'b0;
    if (!en) begin
      cnt_d = '0;
      scl_d = 1'b1;
    end else if (cnt_q == CW'(SCL_HALF - 1)) begin
      cnt_d = '0;
      scl_d = ~scl_q;
      neg_d = scl_q;
      pos_d = ~scl_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      scl_q <= 1'b1;
      neg_q <= 1'b0;
      pos_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      scl_q <= scl_d;
      neg_q <= neg_d;
      pos_q <= pos_d;
    end
  end

  assign SCL             = scl_q;
  assign OneShotNegative = neg_q;
  assign OneShotPositive = pos_q;

endmodule

// File: rtl/i2c_phase1_master.sv
// I2C phase-1 master: START, one address byte, ACK slot, STOP.
// Define I2C_LOCK_WAIT_EN to hold off Go until LOCK_CYCLES clocks after reset.
module i2c_phase1_master
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter logic        RW_BIT      = 1'b0,
  parameter int unsigned SCL_HALF    = 4,
  parameter int unsigned DELAY_COUNT = 3,
  parameter int unsigned LOCK_CYCLES = 8
) (
  input  logic clock,
  input  logic Reset,
  input  logic Go,
  inout  wire  SDA,
  output logic SCL,
  output logic ClockLocked
);

  localparam int unsigned DW = (DELAY_COUNT > 1) ? $clog2(DELAY_COUNT) : 1;

  state_e       state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [3:0]   count_q, count_d;
  logic         sda_low_q, sda_low_d;
  logic         scl_en_q, scl_en_d;
  logic         ack_ok_q, ack_ok_d;
  logic         neg_pulse, pos_pulse;
  logic         locked;

  i2c_scl_gen #(
    .SCL_HALF(SCL_HALF)
  ) u_scl_gen (
    .clock          (clock),
    .Reset          (Reset),
    .en             (scl_en_q),
    .SCL            (SCL),
    .OneShotNegative(neg_pulse),
    .OneShotPositive(pos_pulse)
  );

`ifdef I2C_LOCK_WAIT_EN
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  logic [LW-1:0] lock_cnt_q;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      lock_cnt_q <= '0;
    end else if (lock_cnt_q != LW'(LOCK_CYCLES)) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  assign locked = (lock_cnt_q == LW'(LOCK_CYCLES));
`else
  logic locked_q;

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= 1'b1;
    end
  end

  assign locked = locked_q;
`endif

  assign ClockLocked = locked;
  // Open-drain: only ever pull low.
  assign SDA = sda_low_q ? 1'b0 : 1'bz;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    shreg_d   = shreg_q;
    count_d   = count_q;
    sda_low_d = sda_low_q;
    scl_en_d  = scl_en_q;
    ack_ok_d  = ack_ok_q;
    case (state_q)
      IDLE: begin
        sda_low_d = 1'b0;
        if (Go && locked) begin
          state_d   = START;
          sda_low_d = 1'b1;
          dly_d     = '0;
        end
      end
      START: begin
        if (dly_q == DW'(DELAY_COUNT - 1)) begin
          dly_d   = '0;
          state_d = LOAD;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      LOAD: begin
        shreg_d  = {SLAVE_ADDR, RW_BIT};
        count_d  = BIT_COUNT;
        scl_en_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (neg_pulse) begin
          if (count_q != 4'd0) begin
            sda_low_d = ~shreg_q[7];
            shreg_d   = {shreg_q[6:0], 1'b0};
            count_d   = count_q - 1'b1;
          end else begin
            sda_low_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (pos_pulse) begin
          ack_ok_d = (SDA == 1'b0);
          state_d  = STOP_SETUP;
        end
      end
      STOP_SETUP: begin
        if (neg_pulse) begin
          sda_low_d = 1'b1;
          state_d   = STOP_WAIT;
        end
      end
      STOP_WAIT: begin
        if (pos_pulse) begin
          scl_en_d = 1'b0;
          dly_d    = '0;
          state_d  = STOP;
        end
      end
      STOP: begin
        // SDA rises here with SCL held high: the STOP condition.
        if (dly_q == DW'(DELAY_COUNT - 1)) begin
          dly_d     = '0;
          sda_low_d = 1'b0;
          state_d   = IDLE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      shreg_q   <= '0;
      count_q   <= '0;
      sda_low_q <= 1'b0;
      scl_en_q  <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      shreg_q   <= shreg_d;
      count_q   <= count_d;
      sda_low_q <= sda_low_d;
      scl_en_q  <= scl_en_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

endmodule

// File: tb/tb_i2c_phase1_master.sv
// Bench for i2c_phase1_master: timeline model of one frame checked every cycle, a bus-level
// ACK slave, and hand-computed checks of the captured address byte and frame length.
module tb_i2c_phase1_master;

  localparam int H = 4;
  localparam int D = 3;
`ifdef I2C_LOCK_WAIT_EN
  localparam int LOCKN = 8;
`else
  localparam int LOCKN = 1;
`endif
  localparam int D_IDLE = 2 * D + 20 * H + 2;
  localparam logic [7:0] FRAME = {7'h48, 1'b0};

  logic clock, Reset, Go;
  logic SCL, ClockLocked;
  wire  sda_bus;
  logic slave_low;
  logic ack_en;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  i2c_phase1_master dut (
    .clock      (clock),
    .Reset      (Reset),
    .Go         (Go),
    .SDA        (sda_bus),
    .SCL        (SCL),
    .ClockLocked(ClockLocked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   m_busy = 0;
  int   m_d = 0;
  bit   m_ack = 0;
  int   lock_edges = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected bus/FSM view d cycles after the Go-accept edge, from the frame timeline.
  function automatic void model_at(input int d, input bit ack, output int st, output bit scl,
                                   output bit sda);
    int e;
    int k;
    logic [7:0] fb;
    fb = FRAME;
    e  = d - (D + 1);
    if (d < D)                   st = 1;
    else if (d == D)             st = 2;
    else if (e <= 17 * H)        st = 3;
    else if (e <= 18 * H)        st = 4;
    else if (e <= 19 * H)        st = 5;
    else if (e <= 20 * H)        st = 6;
    else if (e <= 20 * H + D)    st = 7;
    else                         st = 0;
    scl = (e < 0 || e > 20 * H) ? 1'b1 : (((e / H) % 2) == 0);
    if (e <= H) sda = 1'b0;
    else if (e <= 17 * H) begin
      k   = (e - 1 + H) / (2 * H);
      sda = fb[8-k];
    end else if (e < 19 * H)     sda = !ack;
    else if (e == 19 * H)        sda = 1'b1;
    else if (e <= 20 * H + D)    sda = 1'b0;
    else                         sda = 1'b1;
  endfunction

  // ACK slave: counts SCL falls after a START, pulls SDA low from fall 9 to fall 10.
  initial begin
    logic prev_scl, prev_sda;
    int   falls;
    slave_low = 1'b0;
    prev_scl  = 1'b1;
    prev_sda  = 1'b1;
    falls     = 0;
    forever begin
      @(SCL or sda_bus or Reset);
      if (Reset) begin
        falls     = 0;
        slave_low = 1'b0;
      end else if (prev_scl === 1'b1 && SCL === 1'b0) begin
        falls++;
        if (falls == 9) slave_low = ack_en;
        else if (falls == 10) slave_low = 1'b0;
      end else if (prev_sda === 1'b1 && sda_bus === 1'b0 && SCL === 1'b1) begin
        falls     = 0;
        slave_low = 1'b0;
      end
      prev_scl = SCL;
      prev_sda = sda_bus;
    end
  end

  // Compare process: check every cycle, then advance the model to the next edge.
  initial begin
    int   st;
    bit   e_scl, e_sda, e_lock;
    logic prev_scl;
    logic [7:0] cap;
    int   rises, frm_len;
    prev_scl = 1'b1;
    cap = '0;
    rises = 0;
    frm_len = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (Reset) begin
        m_busy     = 0;
        lock_edges = 0;
      end
      if (m_busy) model_at(m_d, m_ack, st, e_scl, e_sda);
      else begin
        st = 0; e_scl = 1'b1; e_sda = 1'b1;
      end
      e_lock = (lock_edges >= LOCKN);
      chk("state", 32'(dut.state_q), 32'(st));
      chk("scl", 32'(SCL), 32'(e_scl));
      chk("sda", {31'b0, sda_bus}, 32'(e_sda));
      chk("clock_locked", 32'(ClockLocked), 32'(e_lock));
      if (m_busy && m_d == D + 1 + 18 * H + 1) chk("ack_ok", 32'(dut.ack_ok_q), 32'(m_ack));
      if (m_busy) begin
        if (32'(dut.state_q) != 0) frm_len++;
        if (prev_scl === 1'b0 && SCL === 1'b1 && rises < 8) begin
          cap = {cap[6:0], sda_bus};
          rises++;
        end
      end
      prev_scl = SCL;
      if (!Reset) begin
        if (lock_edges < 1000) lock_edges++;
        if (m_busy) begin
          m_d++;
          if (m_d == D_IDLE) begin
            m_busy = 0;
            chk("captured_addr_byte", 32'(cap), 32'h90);
            chk("frame_length", 32'(frm_len), 32'd88);
          end
        end else if (Go && e_lock) begin
          m_busy  = 1;
          m_d     = 0;
          m_ack   = ack_en;
          cap     = '0;
          rises   = 0;
          frm_len = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic go_pulse(input int n);
    Go = 1'b1;
    repeat (n) tick();
    Go = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    tick();
    while ((m_busy || 32'(dut.state_q) != 0) && n < maxc) begin
      tick();
      n++;
    end
    tests++;
    if (n >= maxc) begin
      fails++;
      $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int n;
    Reset  = 1'b1;
    Go     = 1'b0;
    ack_en = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;

    // Go held high straight out of reset, slave ACKs.
    Go = 1'b1;
    repeat (10) tick();
    Go = 1'b0;
    wait_idle(200);

    // No ACK: frame still completes with STOP.
    ack_en = 1'b0;
    repeat (3) tick();
    go_pulse(2);
    wait_idle(200);

    // Go toggled during a frame must be ignored.
    ack_en = 1'b1;
    repeat (2) tick();
    go_pulse(2);
    repeat (20) begin
      Go = 1'($urandom_range(0, 1));
      tick();
    end
    Go = 1'b0;
    wait_idle(200);

    // Reset in the middle of SEND.
    go_pulse(2);
    n = 0;
    while (32'(dut.count_q) != 4 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_count4", 32'(dut.count_q), 32'd4);
    Reset = 1'b1;
    #1;
    chk("rst_scl", 32'(SCL), 32'd1);
    chk("rst_sda", {31'b0, sda_bus}, 32'd1);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    repeat (2) tick();
    Reset = 1'b0;
    tick();
    go_pulse(2);
    wait_idle(200);

    // Random Go traffic with occasional resets and random ACK behaviour.
    repeat (800) begin
      if (!m_busy) ack_en = 1'($urandom_range(0, 1));
      Go = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) Reset = 1'b1;
      tick();
      Reset = 1'b0;
    end
    Go = 1'b0;
    wait_idle(200);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
